// File: rtl/debounce_bank.sv
// N-channel pushbutton conditioner: synchroniser, polarity normalisation, debounce,
// press/release strobes, long-press strobe and optional auto-repeat per channel.
module debounce_bank #(
    parameter int N_KEYS        = 4,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int DB_CYCLES     = 250_000,
    parameter int LONG_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] key_repeat,
    output logic              key_any
);

    localparam int CW   = $clog2(DB_CYCLES);
    localparam int HW_L = $clog2(LONG_CYCLES + 1);
    localparam int HW_R = $clog2(REPEAT_CYCLES + 1);
    localparam int HW   = (HW_L > HW_R) ? HW_L : HW_R;

    localparam logic [CW-1:0]     DB_LAST   = CW'(DB_CYCLES - 1);
    localparam logic [HW-1:0]     LONG_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0]     REP_LAST  = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam bit                REP_EN    = (REPEAT_CYCLES > 0);
    localparam logic [N_KEYS-1:0] IDLE_PINS = {N_KEYS{ACTIVE_LOW}};

    logic [N_KEYS-1:0] sync1_q, sync1_d;
    logic [N_KEYS-1:0] sync2_q, sync2_d;
    logic [N_KEYS-1:0] cand_q, cand_d;
    logic [N_KEYS-1:0] level_q, level_d;
    logic [N_KEYS-1:0] press_q, press_d;
    logic [N_KEYS-1:0] release_q, release_d;
    logic [N_KEYS-1:0] long_q, long_d;
    logic [N_KEYS-1:0] repeat_q, repeat_d;
    logic [N_KEYS-1:0] phase_q, phase_d;
    logic [CW-1:0]     cnt_q  [N_KEYS];
    logic [CW-1:0]     cnt_d  [N_KEYS];
    logic [HW-1:0]     hold_q [N_KEYS];
    logic [HW-1:0]     hold_d [N_KEYS];
    logic [N_KEYS-1:0] p_s;

    // Next-state logic: debounce, edge strobes and hold/repeat timing per channel
    always_comb begin
        sync1_d   = key_in;
        sync2_d   = sync1_q;
        p_s       = sync2_q ^ IDLE_PINS;
        cand_d    = cand_q;
        level_d   = level_q;
        phase_d   = phase_q;
        long_d    = '0;
        repeat_d  = '0;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            cnt_d[i]  = cnt_q[i];
            hold_d[i] = hold_q[i];

            if (p_s[i] != cand_q[i]) begin
                cand_d[i] = p_s[i];
                cnt_d[i]  = '0;
            end else if (cnt_q[i] != DB_LAST) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (cand_q[i] != level_q[i]) begin
                level_d[i] = cand_q[i];
            end else begin
                level_d[i] = level_q[i];
            end

            press_d[i]   = level_d[i] & ~level_q[i];
            release_d[i] = ~level_d[i] & level_q[i];

            // Timing only runs while held before and after this edge, so the
            // release-strobe cycle can never carry a long or repeat strobe.
            if (!level_q[i] || !level_d[i]) begin
                hold_d[i]  = '0;
                phase_d[i] = 1'b0;
            end else if (!phase_q[i]) begin
                if (hold_q[i] == LONG_LAST) begin
                    long_d[i]  = 1'b1;
                    phase_d[i] = 1'b1;
                    hold_d[i]  = '0;
                end else begin
                    hold_d[i] = hold_q[i] + HW'(1);
                end
            end else if (REP_EN) begin
                if (hold_q[i] == REP_LAST) begin
                    repeat_d[i] = 1'b1;
                    hold_d[i]   = '0;
                end else begin
                    hold_d[i] = hold_q[i] + HW'(1);
                end
            end else begin
                hold_d[i] = hold_q[i];
            end
        end
    end

    // State registers with asynchronous reset to the released/idle state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= IDLE_PINS;
            sync2_q   <= IDLE_PINS;
            cand_q    <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            repeat_q  <= '0;
            phase_q   <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt_q[i]  <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cand_q    <= cand_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            phase_q   <= phase_d;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt_q[i]  <= cnt_d[i];
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;
    assign key_repeat  = repeat_q;
    assign key_any     = |level_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: one active-low instance with repeat, one
// active-high instance without repeat, both with DB=8 and LONG=20.
module tb_debounce_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] a_in, b_in;
    logic [1:0] a_level, a_press, a_release, a_long, a_repeat;
    logic [1:0] b_level, b_press, b_release, b_long, b_repeat;
    logic       a_any, b_any;
    logic [10:0] a_obs, b_obs;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    debounce_bank #(
        .N_KEYS(2), .ACTIVE_LOW(1'b1), .DB_CYCLES(8), .LONG_CYCLES(20), .REPEAT_CYCLES(5)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .key_in(a_in),
        .key_level(a_level), .key_press(a_press), .key_release(a_release),
        .key_long(a_long), .key_repeat(a_repeat), .key_any(a_any)
    );

    debounce_bank #(
        .N_KEYS(2), .ACTIVE_LOW(1'b0), .DB_CYCLES(8), .LONG_CYCLES(20), .REPEAT_CYCLES(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .key_in(b_in),
        .key_level(b_level), .key_press(b_press), .key_release(b_release),
        .key_long(b_long), .key_repeat(b_repeat), .key_any(b_any)
    );

    assign a_obs = {a_any, a_level, a_press, a_release, a_long, a_repeat};
    assign b_obs = {b_any, b_level, b_press, b_release, b_long, b_repeat};

    // Expected {level, press, release, long, repeat} of one channel after edge c,
    // given the hand-computed edges of press strobe, release strobe, long strobe
    // and the first repeat / repeat period / first edge where repeats stop.
    function automatic logic [4:0] chan(int c, int pr, int rl, int lg, int r0, int rper, int rend);
        logic lv, rp;
        lv = (c >= pr) && (c < rl);
        rp = (rper > 0) && (c >= r0) && (c < rend) && (((c - r0) % rper) == 0);
        return {lv, c == pr, c == rl, c == lg, rp};
    endfunction

    function automatic logic [10:0] pack(logic [4:0] c0, logic [4:0] c1);
        return {c0[4] | c1[4], c1[4], c0[4], c1[3], c0[3], c1[2], c0[2],
                c1[1], c0[1], c1[0], c0[0]};
    endfunction

    task automatic chk(input string tag, input int c, input logic [10:0] obs, input logic [10:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s c=%0d observed=%b expected=%b", tag, c, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] idle;
        idle  = chan(0, 1000, 1000, -1, 0, 0, 0);
        rst_n = 1'b1;
        a_in  = 2'b11;
        b_in  = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_a", 0, a_obs, 11'd0);
        chk("reset_b", 0, b_obs, 11'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("idle_a", c, a_obs, 11'd0);
        end

        // Bounce: low 5, high 3, low 4, then high; never long enough to commit
        a_in[0] = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            chk("bounce", c, a_obs, 11'd0);
            a_in[0] = !((c < 5) || ((c >= 8) && (c < 12)));
        end

        // Clean press held into repeat; release lands on a would-be repeat edge
        a_in[0] = 1'b0;
        for (int c = 1; c <= 75; c++) begin
            @(negedge clk);
            chk("hold_repeat", c, a_obs, pack(chan(c, 11, 61, 31, 36, 5, 61), idle));
            if (c == 50) a_in[0] = 1'b1;
        end

        // Both pressed together; ch1 released after 12 committed cycles
        a_in = 2'b00;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            chk("two_keys", c, a_obs,
                pack(chan(c, 11, 51, 31, 36, 5, 51), chan(c, 11, 23, -1, 0, 0, 0)));
            if (c == 12) a_in[1] = 1'b1;
            if (c == 40) a_in[0] = 1'b1;
        end

        // Reset asserted mid-repeat with the pin still held
        a_in[0] = 1'b0;
        for (int c = 1; c <= 43; c++) begin
            @(negedge clk);
            chk("pre_reset", c, a_obs, pack(chan(c, 11, 1000, 31, 36, 5, 1000), idle));
        end
        rst_n = 1'b0;
        #1;
        chk("reset_async", 0, a_obs, 11'd0);
        @(negedge clk);
        chk("reset_held", 0, a_obs, 11'd0);
        rst_n = 1'b1;
        for (int c = 1; c <= 55; c++) begin
            @(negedge clk);
            chk("post_reset", c, a_obs, pack(chan(c, 11, 51, 31, 36, 5, 51), idle));
            if (c == 40) a_in[0] = 1'b1;
        end

        // Active-high instance without repeat: press, long, then release
        b_in[0] = 1'b1;
        for (int c = 1; c <= 55; c++) begin
            @(negedge clk);
            chk("no_repeat", c, b_obs, pack(chan(c, 11, 51, 31, 0, 0, 0), idle));
            if (c == 40) b_in[0] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
